// File: rtl/button_debounce.sv
// Per-button synchronizer and saturating-counter debouncer with registered level, press pulse and any-press flag.
// Defining BUTTON_DEBOUNCE_RELEASE_EN adds a btn_release output that pulses on each debounced 1->0 transition.
module button_debounce #(
    parameter int NBUTTONS        = 4,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NBUTTONS-1:0] btn_raw,
    output logic [NBUTTONS-1:0] btn_level,
    output logic [NBUTTONS-1:0] btn_press,
    output logic                btn_any_press
`ifdef BUTTON_DEBOUNCE_RELEASE_EN
    ,
    output logic [NBUTTONS-1:0] btn_release
`endif
);

    localparam int CNT_BITS = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_BITS-1:0] CNT_MAX = CNT_BITS'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        STABLE_LO = 2'd0,
        PEND_HI   = 2'd1,
        STABLE_HI = 2'd2,
        PEND_LO   = 2'd3
    } db_state_e;

    // Next-state press vector; btn_any_press registers its OR so it lines up with btn_press.
    logic [NBUTTONS-1:0] press_d;

    generate
        for (genvar gi = 0; gi < NBUTTONS; gi++) begin : g_btn
            logic [SYNC_STAGES-1:0] sync_q;
            logic                   s;
            db_state_e              state_q;
            logic [CNT_BITS-1:0]    cnt_q;
            logic                   level_q;
            logic                   press_q;

            always_ff @(posedge clk) begin
                if (reset) begin
                    sync_q <= '0;
                end else begin
                    sync_q <= {sync_q[SYNC_STAGES-2:0], btn_raw[gi]};
                end
            end

            assign s = sync_q[SYNC_STAGES-1];
            assign press_d[gi] = ~level_q & s & (cnt_q == CNT_MAX);

`ifdef BUTTON_DEBOUNCE_RELEASE_EN
            logic release_q;
`endif

            always_ff @(posedge clk) begin
                if (reset) begin
                    state_q   <= STABLE_LO;
                    cnt_q     <= '0;
                    level_q   <= 1'b0;
                    press_q   <= 1'b0;
`ifdef BUTTON_DEBOUNCE_RELEASE_EN
                    release_q <= 1'b0;
`endif
                end else begin
                    press_q   <= press_d[gi];
`ifdef BUTTON_DEBOUNCE_RELEASE_EN
                    release_q <= 1'b0;
`endif
                    case (state_q)
                        STABLE_LO, PEND_HI: begin
                            if (!s) begin
                                // Input fell back before the count completed: glitch rejected.
                                state_q <= STABLE_LO;
                                cnt_q   <= '0;
                            end else if (cnt_q == CNT_MAX) begin
                                state_q <= STABLE_HI;
                                level_q <= 1'b1;
                                cnt_q   <= '0;
                            end else begin
                                state_q <= PEND_HI;
                                cnt_q   <= cnt_q + CNT_BITS'(1);
                            end
                        end
                        default: begin
                            if (s) begin
                                state_q <= STABLE_HI;
                                cnt_q   <= '0;
                            end else if (cnt_q == CNT_MAX) begin
                                state_q   <= STABLE_LO;
                                level_q   <= 1'b0;
                                cnt_q     <= '0;
`ifdef BUTTON_DEBOUNCE_RELEASE_EN
                                release_q <= 1'b1;
`endif
                            end else begin
                                state_q <= PEND_LO;
                                cnt_q   <= cnt_q + CNT_BITS'(1);
                            end
                        end
                    endcase
                end
            end

            assign btn_level[gi] = level_q;
            assign btn_press[gi] = press_q;
`ifdef BUTTON_DEBOUNCE_RELEASE_EN
            assign btn_release[gi] = release_q;
`endif
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            btn_any_press <= 1'b0;
        end else begin
            btn_any_press <= |press_d;
        end
    end

endmodule

// File: tb/tb_button_debounce.sv
// Randomized and directed bench for button_debounce against a sliding-window reference model.
module tb_button_debounce;

    localparam int N = 4;
    localparam int S = 2;
    localparam int D = 4;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic [N-1:0] btn_raw = '0;
    logic [N-1:0] btn_level;
    logic [N-1:0] btn_press;
    logic         btn_any_press;
`ifdef BUTTON_DEBOUNCE_RELEASE_EN
    logic [N-1:0] btn_release;
`endif

    always #5 clk = ~clk;

    button_debounce #(
        .NBUTTONS(N),
        .SYNC_STAGES(S),
        .DEBOUNCE_CYCLES(D)
    ) dut (
        .clk(clk),
        .reset(reset),
        .btn_raw(btn_raw),
        .btn_level(btn_level),
        .btn_press(btn_press),
        .btn_any_press(btn_any_press)
`ifdef BUTTON_DEBOUNCE_RELEASE_EN
        ,
        .btn_release(btn_release)
`endif
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Model: raw delayed S edges gives s; level flips once the last D values of s all disagree with it.
    logic [N-1:0] m_sync [S];
    logic [N-1:0] m_hist [D];
    logic [N-1:0] m_level = '0;
    logic [N-1:0] exp_press = '0;
    logic         exp_any = 1'b0;
    logic [N-1:0] exp_rel = '0;

    task automatic step(input logic [N-1:0] raw, input logic rst);
        logic [N-1:0] s_now;
        logic [N-1:0] flip;
        logic         all_diff;
        btn_raw = raw;
        reset   = rst;
        @(posedge clk);
        if (rst) begin
            for (int i = 0; i < S; i++) m_sync[i] = '0;
            for (int i = 0; i < D; i++) m_hist[i] = '0;
            m_level   = '0;
            exp_press = '0;
            exp_rel   = '0;
            exp_any   = 1'b0;
        end else begin
            s_now = m_sync[S-1];
            for (int i = S - 1; i > 0; i--) m_sync[i] = m_sync[i-1];
            m_sync[0] = raw;
            for (int i = D - 1; i > 0; i--) m_hist[i] = m_hist[i-1];
            m_hist[0] = s_now;
            for (int b = 0; b < N; b++) begin
                all_diff = 1'b1;
                for (int i = 0; i < D; i++)
                    if (m_hist[i][b] == m_level[b]) all_diff = 1'b0;
                flip[b] = all_diff;
            end
            exp_press = flip & ~m_level;
            exp_rel   = flip & m_level;
            exp_any   = |exp_press;
            m_level   = m_level ^ flip;
        end
        #1;
    endtask

    task automatic test_reset;
        int press_edge;
        for (int c = 0; c < 3; c++) begin
            step(4'b1111, 1'b1);
            n_checks++;
            if ({btn_level, btn_press, btn_any_press} !== '0) begin
                n_fail++;
                $display("FAIL reset_outputs cycle %0d got lvl=%b prs=%b any=%b need all 0", c, btn_level, btn_press, btn_any_press);
            end
        end
        press_edge = -1;
        for (int e = 0; e < 10; e++) begin
            step(4'b0001, 1'b0);
            n_checks++;
            if (btn_level !== m_level || btn_press !== exp_press || btn_any_press !== exp_any) begin
                n_fail++;
                $display("FAIL reset_latency edge %0d got lvl=%b prs=%b any=%b need lvl=%b prs=%b any=%b",
                         e, btn_level, btn_press, btn_any_press, m_level, exp_press, exp_any);
            end
            if (btn_press !== 4'b0000 && press_edge < 0) press_edge = e;
        end
        n_checks++;
        if (press_edge != 5) begin
            n_fail++;
            $display("FAIL press_latency got edge %0d need edge 5", press_edge);
        end
        n_checks++;
        if (btn_level !== 4'b0001) begin
            n_fail++;
            $display("FAIL level_after_press got %b need 0001", btn_level);
        end
    endtask

    task automatic test_glitch;
        logic [6:0] pat;
        logic [N-1:0] raw;
        pat = 7'b1110111;
        step('0, 1'b1);
        step('0, 1'b1);
        for (int c = 0; c < 17; c++) begin
            raw = '0;
            raw[1] = (c < 7) ? pat[6-c] : 1'b0;
            step(raw, 1'b0);
            n_checks++;
            if (btn_level[1] !== 1'b0 || btn_press[1] !== 1'b0 || btn_level !== m_level || btn_press !== exp_press) begin
                n_fail++;
                $display("FAIL glitch cycle %0d got lvl=%b prs=%b need lvl=%b prs=%b", c, btn_level, btn_press, m_level, exp_press);
            end
        end
    endtask

    task automatic test_bounce;
        logic [N-1:0] raw;
        int press_cnt;
        int press_c;
        step('0, 1'b1);
        step('0, 1'b1);
        press_cnt = 0;
        press_c   = -1;
        for (int c = 0; c < 22; c++) begin
            raw = '0;
            raw[2] = (c >= 10) ? 1'b1 : ((c % 2) == 0);
            step(raw, 1'b0);
            n_checks++;
            if (btn_level !== m_level || btn_press !== exp_press || btn_any_press !== exp_any) begin
                n_fail++;
                $display("FAIL bounce cycle %0d got lvl=%b prs=%b any=%b need lvl=%b prs=%b any=%b",
                         c, btn_level, btn_press, btn_any_press, m_level, exp_press, exp_any);
            end
            if (btn_press[2] === 1'b1) begin
                press_cnt++;
                press_c = c;
            end
        end
        n_checks++;
        if (press_cnt != 1 || press_c != 15) begin
            n_fail++;
            $display("FAIL bounce_press got %0d pulses last at %0d need 1 pulse at 15", press_cnt, press_c);
        end
        n_checks++;
        if (btn_level[2] !== 1'b1) begin
            n_fail++;
            $display("FAIL bounce_level got %b need 1", btn_level[2]);
        end
    endtask

    task automatic test_simultaneous;
        int both_cnt;
        int other_press;
        int drop_c;
        int rel_cnt;
        int rel_c;
        step('0, 1'b1);
        step('0, 1'b1);
        both_cnt = 0;
        other_press = 0;
        drop_c = -1;
        rel_cnt = 0;
        rel_c = -1;
        for (int c = 0; c < 20; c++) begin
            step((c < 10) ? 4'b1001 : 4'b1000, 1'b0);
            n_checks++;
            if (btn_level !== m_level || btn_press !== exp_press || btn_any_press !== exp_any) begin
                n_fail++;
                $display("FAIL simul cycle %0d got lvl=%b prs=%b any=%b need lvl=%b prs=%b any=%b",
                         c, btn_level, btn_press, btn_any_press, m_level, exp_press, exp_any);
            end
            if (btn_press === 4'b1001 && btn_any_press === 1'b1) both_cnt++;
            else if (btn_press !== 4'b0000) other_press++;
            if (c >= 10 && btn_level[0] === 1'b0 && drop_c < 0) drop_c = c;
`ifdef BUTTON_DEBOUNCE_RELEASE_EN
            n_checks++;
            if (btn_release !== exp_rel) begin
                n_fail++;
                $display("FAIL simul_release cycle %0d got %b need %b", c, btn_release, exp_rel);
            end
            if (btn_release === 4'b0001) begin
                rel_cnt++;
                rel_c = c;
            end
`endif
        end
        n_checks++;
        if (both_cnt != 1 || other_press != 0) begin
            n_fail++;
            $display("FAIL simul_press got %0d joint pulses %0d other need 1 and 0", both_cnt, other_press);
        end
        n_checks++;
        if (drop_c != 15) begin
            n_fail++;
            $display("FAIL release_latency got cycle %0d need 15", drop_c);
        end
`ifdef BUTTON_DEBOUNCE_RELEASE_EN
        n_checks++;
        if (rel_cnt != 1 || rel_c != 15) begin
            n_fail++;
            $display("FAIL release_pulse got %0d pulses at %0d need 1 at 15", rel_cnt, rel_c);
        end
`endif
    endtask

    task automatic test_reset_mid;
        int press_edge;
        step('0, 1'b1);
        step('0, 1'b1);
        for (int c = 0; c < 4; c++) step(4'b0001, 1'b0);
        step(4'b0001, 1'b1);
        n_checks++;
        if ({btn_level, btn_press, btn_any_press} !== '0) begin
            n_fail++;
            $display("FAIL midreset_outputs got lvl=%b prs=%b any=%b need all 0", btn_level, btn_press, btn_any_press);
        end
        press_edge = -1;
        for (int e = 0; e < 9; e++) begin
            step(4'b0001, 1'b0);
            n_checks++;
            if (btn_level !== m_level || btn_press !== exp_press) begin
                n_fail++;
                $display("FAIL midreset edge %0d got lvl=%b prs=%b need lvl=%b prs=%b", e, btn_level, btn_press, m_level, exp_press);
            end
            if (btn_press[0] === 1'b1 && press_edge < 0) press_edge = e;
        end
        n_checks++;
        if (press_edge != 5) begin
            n_fail++;
            $display("FAIL midreset_latency got edge %0d need 5", press_edge);
        end
    endtask

    task automatic test_random;
        logic [N-1:0] raw;
        logic         rst;
        raw = '0;
        step('0, 1'b1);
        for (int c = 0; c < 800; c++) begin
            for (int b = 0; b < N; b++)
                if ($urandom_range(0, 6) == 0) raw[b] = ~raw[b];
            rst = ($urandom_range(0, 149) == 0);
            step(raw, rst);
            n_checks++;
            if (btn_level !== m_level || btn_press !== exp_press || btn_any_press !== exp_any) begin
                n_fail++;
                $display("FAIL random cycle %0d got lvl=%b prs=%b any=%b need lvl=%b prs=%b any=%b",
                         c, btn_level, btn_press, btn_any_press, m_level, exp_press, exp_any);
            end
`ifdef BUTTON_DEBOUNCE_RELEASE_EN
            n_checks++;
            if (btn_release !== exp_rel) begin
                n_fail++;
                $display("FAIL random_release cycle %0d got %b need %b", c, btn_release, exp_rel);
            end
`endif
        end
    endtask

    initial begin
        for (int i = 0; i < S; i++) m_sync[i] = '0;
        for (int i = 0; i < D; i++) m_hist[i] = '0;
        test_reset;
        test_glitch;
        test_bounce;
        test_simultaneous;
        test_reset_mid;
        test_random;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
